// File: rtl/halfbridge_timing_generator.sv
// rtl/halfbridge_timing_generator.sv - half-bridge period counter and dead-time edge-tick generator
// Optional duty_clamped output guarded by HALFBRIDGE_CLAMP_FLAG_EN.
module halfbridge_timing_generator #(
  parameter int bitwidth       = 10,
  parameter int default_period = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                load,
  input  logic [bitwidth-1:0] period_in,
  input  logic [bitwidth-1:0] duty_in,
  input  logic [bitwidth-1:0] deadtime_in,
  output logic                busy,
  output logic                update_ack,
  output logic                update_error,
  output logic [bitwidth-1:0] counter_value,
  output logic [bitwidth-1:0] hs_rising_tick,
  output logic [bitwidth-1:0] hs_falling_tick,
  output logic [bitwidth-1:0] ls_rising_tick,
  output logic [bitwidth-1:0] ls_falling_tick
`ifdef HALFBRIDGE_CLAMP_FLAG_EN
  ,output logic               duty_clamped
`endif
);

  localparam logic [bitwidth-1:0] reset_period = bitwidth'(default_period);
  localparam logic [bitwidth-1:0] one_tick     = bitwidth'(1);
  localparam logic [bitwidth:0]   one_ext      = (bitwidth + 1)'(1);
  localparam logic [bitwidth:0]   three_ext    = (bitwidth + 1)'(3);

  typedef enum logic [1:0] {IDLE, CHECK, PENDING} state_t;

  state_t state, next_state;

  logic [bitwidth-1:0] period_r;
  logic [bitwidth-1:0] req_period, req_duty, req_deadtime;
  logic [bitwidth-1:0] sh_period, sh_hs_rising, sh_hs_falling, sh_ls_rising;
  logic                sh_clamped;
  logic                clamped_r;

  logic capture, commit, apply, wrap;

  logic [bitwidth:0] dt_ext, two_dt1, per_ext, duty_ext, dmax, d_ext;
  logic [bitwidth:0] hs_falling_ext, ls_rising_ext;
  logic              reject, clamp_flag;

  assign wrap = run && (counter_value == period_r - one_tick);

  // Clamp arithmetic is one bit wider so 2*dt+1 never wraps.
  always_comb begin
    dt_ext         = (req_deadtime == '0) ? one_ext : {1'b0, req_deadtime};
    two_dt1        = (dt_ext << 1) + one_ext;
    per_ext        = {1'b0, req_period};
    duty_ext       = {1'b0, req_duty};
    reject         = (per_ext < three_ext) || (two_dt1 > per_ext);
    dmax           = per_ext - two_dt1;
    d_ext          = (duty_ext > dmax) ? dmax : duty_ext;
    hs_falling_ext = dt_ext + d_ext;
    ls_rising_ext  = (dt_ext << 1) + d_ext;
    clamp_flag     = (duty_ext > dmax) || (req_deadtime == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    capture      = 1'b0;
    commit       = 1'b0;
    apply        = 1'b0;
    update_error = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture    = 1'b1;
          next_state = CHECK;
        end
      end
      CHECK: begin
        if (reject) begin
          update_error = 1'b1;
          next_state   = IDLE;
        end else begin
          commit     = 1'b1;
          next_state = PENDING;
        end
      end
      PENDING: begin
        // Stopped counter has no wrap to wait for, so apply immediately.
        if (!run || wrap) begin
          apply      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      req_period    <= '0;
      req_duty      <= '0;
      req_deadtime  <= '0;
      sh_period     <= reset_period;
      sh_hs_rising  <= '0;
      sh_hs_falling <= '0;
      sh_ls_rising  <= '0;
      sh_clamped    <= 1'b0;
    end else begin
      if (capture) begin
        req_period   <= period_in;
        req_duty     <= duty_in;
        req_deadtime <= deadtime_in;
      end
      if (commit) begin
        sh_period     <= req_period;
        sh_hs_rising  <= dt_ext[bitwidth-1:0];
        sh_hs_falling <= hs_falling_ext[bitwidth-1:0];
        sh_ls_rising  <= ls_rising_ext[bitwidth-1:0];
        sh_clamped    <= clamp_flag;
      end
    end
  end

  // Period, ticks and counter wrap all switch on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter_value   <= '0;
      period_r        <= reset_period;
      hs_rising_tick  <= '0;
      hs_falling_tick <= '0;
      ls_rising_tick  <= '0;
      clamped_r       <= 1'b0;
      update_ack      <= 1'b0;
    end else begin
      update_ack <= apply;
      if (!run || wrap) counter_value <= '0;
      else              counter_value <= counter_value + one_tick;
      if (apply) begin
        period_r        <= sh_period;
        hs_rising_tick  <= sh_hs_rising;
        hs_falling_tick <= sh_hs_falling;
        ls_rising_tick  <= sh_ls_rising;
        clamped_r       <= sh_clamped;
      end
    end
  end

  assign ls_falling_tick = '0;

`ifdef HALFBRIDGE_CLAMP_FLAG_EN
  assign duty_clamped = clamped_r;
`else
  logic unused_clamp;
  assign unused_clamp = clamped_r;
`endif

endmodule

// File: tb/tb_halfbridge_timing_generator.sv
// tb/tb_halfbridge_timing_generator.sv - directed self-checking bench for halfbridge_timing_generator
module tb_halfbridge_timing_generator;

  logic       clock = 1'b0;
  logic       reset, run, load;
  logic [9:0] period_in, duty_in, deadtime_in;
  logic       busy, update_ack, update_error;
  logic [9:0] counter_value, hs_rising_tick, hs_falling_tick, ls_rising_tick, ls_falling_tick;
`ifdef HALFBRIDGE_CLAMP_FLAG_EN
  logic       duty_clamped;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  halfbridge_timing_generator #(.bitwidth(10), .default_period(1000)) dut (
    .clock(clock), .reset(reset), .run(run), .load(load),
    .period_in(period_in), .duty_in(duty_in), .deadtime_in(deadtime_in),
    .busy(busy), .update_ack(update_ack), .update_error(update_error),
    .counter_value(counter_value),
    .hs_rising_tick(hs_rising_tick), .hs_falling_tick(hs_falling_tick),
    .ls_rising_tick(ls_rising_tick), .ls_falling_tick(ls_falling_tick)
`ifdef HALFBRIDGE_CLAMP_FLAG_EN
    ,.duty_clamped(duty_clamped)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ticks(input string tag, input logic [9:0] hr, input logic [9:0] hf,
                           input logic [9:0] lr);
    chk({tag, "_hs_rise"}, hs_rising_tick, hr);
    chk({tag, "_hs_fall"}, hs_falling_tick, hf);
    chk({tag, "_ls_rise"}, ls_rising_tick, lr);
    chk({tag, "_ls_fall"}, ls_falling_tick, 0);
  endtask

  task automatic wait_count(input string tag, input logic [9:0] target);
    int n = 0;
    while (counter_value !== target && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, counter_value, target);
  endtask

  task automatic do_load(input logic [9:0] p, input logic [9:0] d, input logic [9:0] t);
    period_in = p; duty_in = d; deadtime_in = t;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; load = 1'b0;
    period_in = '0; duty_in = '0; deadtime_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_counter", counter_value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", update_ack, 0);
    chk("rst_err", update_error, 0);
    chk_ticks("rst", 0, 0, 0);

    // Default period 1000 count and wrap
    run = 1'b1;
    tick();
    chk("run_first", counter_value, 1);
    wait_count("def999", 999);
    tick();
    chk("def_wrap", counter_value, 0);
    chk_ticks("def", 0, 0, 0);

    // 100/40/5 applies only at the wrap of the old period
    do_load(100, 40, 5);
    chk("l1_busy", busy, 1);
    chk("l1_err", update_error, 0);
    tick();
    chk("l1_pend_busy", busy, 1);
    wait_count("l1_pre", 999);
    chk("l1_pre_ack", update_ack, 0);
    chk_ticks("l1_pre", 0, 0, 0);
    tick();
    chk("l1_ack", update_ack, 1);
    chk("l1_cnt", counter_value, 0);
    chk("l1_busy_done", busy, 0);
    chk_ticks("l1", 5, 45, 50);
`ifdef HALFBRIDGE_CLAMP_FLAG_EN
    chk("l1_clamp", duty_clamped, 0);
`endif
    tick();
    chk("l1_ack_pulse", update_ack, 0);
    wait_count("l1_99", 99);
    tick();
    chk("l1_wrap100", counter_value, 0);

    // Duty clamped to period - 2*dt - 1
    do_load(100, 95, 5);
    tick();
    wait_count("l2_pre", 99);
    tick();
    chk("l2_ack", update_ack, 1);
    chk_ticks("l2", 5, 94, 99);
`ifdef HALFBRIDGE_CLAMP_FLAG_EN
    chk("l2_clamp", duty_clamped, 1);
`endif

    // Rejected request: dead time does not fit in period 10
    do_load(10, 3, 5);
    chk("l3_busy", busy, 1);
    chk("l3_err", update_error, 1);
    tick();
    chk("l3_err_pulse", update_error, 0);
    chk("l3_busy_done", busy, 0);
    chk("l3_no_ack", update_ack, 0);
    wait_count("l3_99", 99);
    tick();
    chk("l3_wrap100", counter_value, 0);
    chk("l3_no_ack2", update_ack, 0);
    chk_ticks("l3", 5, 94, 99);

    // Zero dead time forced to 1
    do_load(100, 10, 0);
    tick();
    wait_count("l4_pre", 99);
    tick();
    chk("l4_ack", update_ack, 1);
    chk_ticks("l4", 1, 11, 12);
`ifdef HALFBRIDGE_CLAMP_FLAG_EN
    chk("l4_clamp", duty_clamped, 1);
`endif

    // Second load while pending is dropped
    do_load(100, 20, 3);
    tick();
    do_load(50, 10, 2);
    chk("l5_busy", busy, 1);
    chk("l5_err", update_error, 0);
    chk_ticks("l5_hold", 1, 11, 12);
    wait_count("l5_pre", 99);
    tick();
    chk("l5_ack", update_ack, 1);
    chk_ticks("l5", 3, 23, 26);
    wait_count("l5_49", 49);
    tick();
    chk("l5_period100", counter_value, 50);

    // Reset while pending drops the request
    do_load(100, 30, 4);
    tick();
    chk("l6_pend", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("l6_cnt", counter_value, 0);
    chk("l6_busy", busy, 0);
    chk_ticks("l6", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("l6_no_ack", update_ack, 0);
    end
    chk_ticks("l6_after", 0, 0, 0);

    // Stopped counter applies on the next edge
    run = 1'b0;
    tick();
    chk("l7_hold", counter_value, 0);
    do_load(200, 50, 10);
    chk("l7_busy", busy, 1);
    tick();
    chk("l7_pend_ack", update_ack, 0);
    chk_ticks("l7_pend", 0, 0, 0);
    tick();
    chk("l7_ack", update_ack, 1);
    chk("l7_cnt", counter_value, 0);
    chk("l7_busy_done", busy, 0);
    chk_ticks("l7", 10, 60, 70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/halfbridge_timing_generator.md
Name: halfbridge_timing_generator

Overview:
Period counter and edge-tick generator for one half-bridge leg. It sits directly upstream of the two pulse generators (high side, low side). It drives the shared counter_value and the rising/falling tick numbers for both switches. It converts a requested period, high-side on-time and dead time into clamped, glitch-free tick numbers, and applies new settings only at the period boundary (shadow-register update).

Parameters:
bitwidth, 10, width of counter, period and all tick numbers
default_period, 1000, period (ticks) loaded at reset; must be < 2**bitwidth and >= 3

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  1 = counter runs; 0 = counter held at 0
load  input  1  one-cycle strobe: sample period_in/duty_in/deadtime_in; ignored while busy=1
period_in  input  bitwidth  requested period in ticks
duty_in  input  bitwidth  requested high-side on-time in ticks
deadtime_in  input  bitwidth  requested dead time in ticks
busy  output  1  update in progress (state != IDLE)
update_ack  output  1  one-cycle pulse when new settings take effect
update_error  output  1  one-cycle pulse when a request is rejected
counter_value  output  bitwidth  current tick, 0..period-1
hs_rising_tick  output  bitwidth  high-side rising-edge tick
hs_falling_tick  output  bitwidth  high-side falling-edge tick
ls_rising_tick  output  bitwidth  low-side rising-edge tick
ls_falling_tick  output  bitwidth  low-side falling-edge tick

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - counter_value=0; active period=default_period; all four tick outputs=0.
  - rising==falling means the downstream pulse stays low, so both switches are off.
  - busy=0, update_ack=0, update_error=0, state=IDLE.
  - Reset mid-update discards the pending request.
- Counter:
  - When run=1: counts 0..period-1 and wraps to 0.
  - When run=0: held at 0.
- Computation (internal width bitwidth+1, no overflow):
  - dt = max(deadtime_in, 1).
  - Reject if period_in < 3 or 2*dt+1 > period_in.
  - d = min(duty_in, period_in - 2*dt - 1); this guarantees at least one low-side tick.
  - hs_rising = dt; hs_falling = dt + d.
  - ls_rising = 2*dt + d; ls_falling = 0.
  - d=0 gives hs_rising == hs_falling, so the high side stays off; this is legal.
- State machine IDLE -> CHECK -> PENDING -> IDLE:
  - IDLE: load=1 registers the inputs; go to CHECK next cycle.
  - CHECK (1 cycle):
    - Compute and clamp into shadow registers.
    - On reject: update_error=1 for that single cycle; return to IDLE; active values unchanged.
    - Otherwise go to PENDING.
  - PENDING, run=1: on the edge where counter goes period-1 -> 0, the shadow values become active together with the wrap. In that cycle counter_value=0, the new ticks are visible and update_ack=1. Return to IDLE.
  - PENDING, run=0: apply on the next clock edge with update_ack=1.
  - load while busy=1 is ignored (no queueing).
  - Latency: load at edge N; error at N+1 (cycle after); apply no earlier than edge N+2.
- All four tick outputs and the period change in the same cycle; no mixed old/new set is ever visible.
- Changing period to a value <= the current counter_value takes effect only at wrap, so the counter never exceeds the old period-1.

Optional Feature:
HALFBRIDGE_CLAMP_FLAG_EN
- Defined: adds output duty_clamped (1 bit). It is registered with the shadow values and becomes active at update. It reads 1 if duty_in was reduced or deadtime_in was forced from 0 to 1. Reset value 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then run=1 -> counter_value counts 0..999 and wraps; all tick outputs read 0; busy=0.
- load with period 100, duty 40, deadtime 5 -> busy the cycle after. At the next wrap: ticks 5/45/50/0, counter wraps at 99, update_ack for one cycle; no change before the wrap.
- load with period 100, duty 95, deadtime 5 -> ticks 5/94/99/0; duty_clamped=1 if HALFBRIDGE_CLAMP_FLAG_EN is defined.
- load with period 10, deadtime 5 -> update_error pulse; previous ticks/period retained; busy returns to 0; no update_ack. load with deadtime 0, duty 10, period 100 -> ticks 1/11/12/0.
- Second load during PENDING with different values -> ignored; the first request is applied. reset asserted in PENDING -> request dropped; tick outputs 0; no update_ack.
- run=0 with PENDING -> applied on the next edge with update_ack; counter stays 0.
